id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register of the 5-stage core. Captures decoded operands and control,
//  detects load-use hazards against the instruction now in EX, inserts bubbles on
//  load-use or branch flush, and bypasses same-cycle WB writes into captured operands.
//  Its registered addr/data/RegWEn outputs feed the EX-stage forwarding mux directly.
// PARAMETERS
//  XLEN    32  operand/PC/immediate width
//  CTRL_W  16  width of opaque EX/ME/WB control bundle (passed through, zeroed on bubble)
// PORTS
//  clk            in   1       rising-edge clock
//  rstn           in   1       asynchronous active-low reset
//  id_valid       in   1       ID holds a real instruction
//  id_pc          in   XLEN    ID PC
//  id_rs1/id_rs2  in   5       source register addresses
//  id_use_rs1/2   in   1       instruction actually reads rs1/rs2
//  id_rd          in   5       destination register
//  id_rs1_data/2  in   XLEN    register-file read data
//  id_imm         in   XLEN    decoded immediate
//  id_regwen      in   1       ID writes rd
//  id_memread     in   1       ID is a load
//  id_memwrite    in   1       ID is a store
//  id_ctrl        in   CTRL_W  remaining control bundle
//  wb_regwen      in   1       WB-stage register write enable
//  wb_addr        in   5       WB destination
//  wb_data        in   XLEN    WB write data
//  mem_stall      in   1       IM/DM wait; freezes whole pipeline
//  ex_flush       in   1       taken branch/jump resolved in EX
//  hazard_stall   out  1       load-use: hold PC and IF/ID this cycle
//  ex_valid       out  1       EX holds a real instruction
//  ex_pc, ex_imm  out  XLEN    registered PC/immediate
//  ex_rs1/ex_rs2  out  5       registered source addrs (forwarding compare)
//  ex_rd          out  5       registered destination
//  ex_rs1_data/2  out  XLEN    registered operands (forwarding default path)
//  ex_regwen, ex_memread, ex_memwrite  out 1  registered control
//  ex_ctrl        out  CTRL_W  registered control bundle
//  bubble_cnt     out  32      count of load-use bubbles inserted
// BEHAVIOUR
//  Reset (rstn=0, async): every ex_* output, bubble_cnt and valid = 0; hazard_stall=0.
//  load_use (comb) = ex_valid & ex_memread & ex_rd!=0 & id_valid &
//    ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  hazard_stall = load_use & ~ex_flush (combinational, same cycle).
//  Per rising edge, priority order:
//   1 mem_stall=1: all registers hold (incl. bubble_cnt); flush/load_use ignored.
//   2 ex_flush=1: bubble -> ex_valid, ex_regwen, ex_memread, ex_memwrite, ex_ctrl,
//     ex_rs1, ex_rs2, ex_rd <= 0; data/pc/imm don't-care (hold).
//   3 load_use=1: same bubble; bubble_cnt += 1, saturating at 2^32-1.
//   4 else capture ID: ex_valid<=id_valid; all fields <= id_*; if id_valid=0, control
//     and addrs captured as 0 (invalid never writes).
//  WB bypass on capture: if wb_regwen & wb_addr!=0 & wb_addr==id_rs1 then
//    ex_rs1_data<=wb_data else id_rs1_data; same independently for rs2.
//  Latency 1 cycle ID->EX. A load followed by a dependent op costs exactly 1 bubble;
//  the next cycle load_use is 0 because EX now holds the bubble (ex_valid=0).
//  x0: rd/rs of 0 never triggers load_use or WB bypass.
//  Reset mid-operation: pipeline contents discarded, first post-reset edge captures ID.
// TESTING
//  T1 reset: rstn=0 mid-traffic -> all ex_*=0, bubble_cnt=0 immediately (no clk edge).
//  T2 lw x5 then add x6,x5,x7 -> 1 cycle hazard_stall=1, EX bubble, add enters next
//     cycle, bubble_cnt=1.
//  T3 lw x0 then add x6,x0,x1 -> no stall; lw x5 then add x6,x1,x2 -> no stall.
//  T4 load_use & ex_flush same cycle -> hazard_stall=0, bubble, bubble_cnt unchanged.
//  T5 mem_stall=1 for 3 cycles with load_use pending -> all ex_* and bubble_cnt frozen;
//     on release bubble inserted once.
//  T6 wb_regwen=1 wb_addr=3 wb_data=0xDEADBEEF, id_rs1=id_rs2=3, rf data=0x1 ->
//     ex_rs1_data=ex_rs2_data=0xDEADBEEF; with wb_addr=0 -> both 0x1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: load-use hazard detection, bubble insertion on
// load-use or flush, and same-cycle WB bypass into the captured operands.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_regwen,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_regwen,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              mem_stall,
  input  logic              ex_flush,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic              ex_regwen,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       bubble_cnt
);

  logic            load_use;
  logic            wb_hit1;
  logic            wb_hit2;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  always_comb begin
    load_use = ex_valid && ex_memread && (ex_rd != 5'd0) && id_valid &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    hazard_stall = load_use && !ex_flush;
    wb_hit1 = wb_regwen && (wb_addr != 5'd0) && (wb_addr == id_rs1);
    wb_hit2 = wb_regwen && (wb_addr != 5'd0) && (wb_addr == id_rs2);
    rs1_fwd = wb_hit1 ? wb_data : id_rs1_data;
    rs2_fwd = wb_hit2 ? wb_data : id_rs2_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_regwen   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_ctrl     <= '0;
      bubble_cnt  <= '0;
    end else if (!mem_stall) begin
      if (ex_flush || load_use) begin
        // Bubble: kill control and addresses; data/pc/imm are left holding.
        ex_valid    <= 1'b0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_regwen   <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_ctrl     <= '0;
        if (!ex_flush && (bubble_cnt != '1))
          bubble_cnt <= bubble_cnt + 32'd1;
      end else begin
        ex_valid    <= id_valid;
        ex_pc       <= id_pc;
        ex_imm      <= id_imm;
        ex_rs1_data <= rs1_fwd;
        ex_rs2_data <= rs2_fwd;
        ex_rs1      <= id_valid ? id_rs1 : 5'd0;
        ex_rs2      <= id_valid ? id_rs2 : 5'd0;
        ex_rd       <= id_valid ? id_rd  : 5'd0;
        ex_regwen   <= id_valid && id_regwen;
        ex_memread  <= id_valid && id_memread;
        ex_memwrite <= id_valid && id_memwrite;
        ex_ctrl     <= id_valid ? id_ctrl : '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed ID/WB vectors with hand-computed
// expected EX state queued per cycle; a monitor pops and compares after each edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [31:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic        id_regwen = 1'b0, id_memread = 1'b0, id_memwrite = 1'b0;
  logic [15:0] id_ctrl = '0;
  logic        wb_regwen = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        mem_stall = 1'b0, ex_flush = 1'b0;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, bubble_cnt;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_regwen, ex_memread, ex_memwrite;
  logic [15:0] ex_ctrl;

  id_ex_stage #(.XLEN(32), .CTRL_W(16)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_regwen(id_regwen), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_ctrl(id_ctrl), .wb_regwen(wb_regwen), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_stall(mem_stall), .ex_flush(ex_flush), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_regwen(ex_regwen), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hz;
    bit          v;
    logic [4:0]  rd, rs1, rs2;
    bit          rw, mr, mw;
    logic [15:0] ctrl;
    logic [31:0] d1, d2, pc, imm, bc;
    bit          chkd;
  } exp_t;

  localparam int CAP = 0, BUB = 1, HOLD = 2;

  exp_t        q[$];
  exp_t        last;
  int unsigned tests = 0, fails = 0;
  logic [31:0] pc_next = 32'h1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Registers read back as 0x100+rs1 / 0x200+rs2 unless overridden.
  task automatic put(input bit mr, input bit mw, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid    = 1'b1;
    id_pc       = pc_next;
    pc_next     = pc_next + 32'd4;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_use_rs1  = 1'b1;
    id_use_rs2  = 1'b1;
    id_rd       = rd;
    id_rs1_data = 32'h100 + {27'd0, rs1};
    id_rs2_data = 32'h200 + {27'd0, rs2};
    id_imm      = 32'hA00 + {27'd0, rd};
    id_regwen   = !mw;
    id_memread  = mr;
    id_memwrite = mw;
    id_ctrl     = 16'h5A00 ^ {11'd0, rd};
  endtask

  task automatic step(input bit hz, input int kind, input logic [31:0] bc,
                      input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e = last;
    if (kind == CAP) begin
      e.v    = id_valid;
      e.rd   = id_valid ? id_rd  : 5'd0;
      e.rs1  = id_valid ? id_rs1 : 5'd0;
      e.rs2  = id_valid ? id_rs2 : 5'd0;
      e.rw   = id_valid && id_regwen;
      e.mr   = id_valid && id_memread;
      e.mw   = id_valid && id_memwrite;
      e.ctrl = id_valid ? id_ctrl : 16'd0;
      e.d1   = d1;
      e.d2   = d2;
      e.pc   = id_pc;
      e.imm  = id_imm;
      e.chkd = 1'b1;
    end else if (kind == BUB) begin
      e.v = 1'b0; e.rd = '0; e.rs1 = '0; e.rs2 = '0;
      e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.ctrl = '0;
      e.chkd = 1'b0;
    end
    e.hz = hz;
    e.bc = bc;
    last = e;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q[0];
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, e.hz});
        @(posedge clk);
        #1;
        chk("ex_valid",    {31'd0, ex_valid},    {31'd0, e.v});
        chk("ex_rd",       {27'd0, ex_rd},       {27'd0, e.rd});
        chk("ex_rs1",      {27'd0, ex_rs1},      {27'd0, e.rs1});
        chk("ex_rs2",      {27'd0, ex_rs2},      {27'd0, e.rs2});
        chk("ex_regwen",   {31'd0, ex_regwen},   {31'd0, e.rw});
        chk("ex_memread",  {31'd0, ex_memread},  {31'd0, e.mr});
        chk("ex_memwrite", {31'd0, ex_memwrite}, {31'd0, e.mw});
        chk("ex_ctrl",     {16'd0, ex_ctrl},     {16'd0, e.ctrl});
        chk("bubble_cnt",  bubble_cnt,           e.bc);
        if (e.chkd) begin
          chk("ex_rs1_data", ex_rs1_data, e.d1);
          chk("ex_rs2_data", ex_rs2_data, e.d2);
          chk("ex_pc",       ex_pc,       e.pc);
          chk("ex_imm",      ex_imm,      e.imm);
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin : stim
    last = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_bubble_cnt", bubble_cnt, 32'd0);
    chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);
    @(negedge clk);
    #1;
    rstn = 1'b1;

    // load-use: lw x5 ; add x6,x5,x7 -> one bubble
    put(1, 0, 5, 1, 2);  step(0, CAP, 0, 32'h101, 32'h202);
    put(0, 0, 6, 5, 7);  step(1, BUB, 1, 0, 0);
                         step(0, CAP, 1, 32'h105, 32'h207);
    // x0 destination and independent consumer never stall
    put(1, 0, 0, 1, 2);  step(0, CAP, 1, 32'h101, 32'h202);
    put(0, 0, 6, 0, 1);  step(0, CAP, 1, 32'h100, 32'h201);
    put(1, 0, 5, 1, 2);  step(0, CAP, 1, 32'h101, 32'h202);
    put(0, 0, 6, 1, 2);  step(0, CAP, 1, 32'h101, 32'h202);
    // load-use coinciding with flush: bubble, no count
    put(1, 0, 8, 3, 4);  step(0, CAP, 1, 32'h103, 32'h204);
    put(0, 0, 9, 1, 8);  ex_flush = 1'b1; step(0, BUB, 1, 0, 0);
    ex_flush = 1'b0;     step(0, CAP, 1, 32'h101, 32'h208);
    // mem_stall freezes a pending load-use for 3 cycles
    put(1, 0, 10, 1, 2); step(0, CAP, 1, 32'h101, 32'h202);
    put(0, 1, 0, 10, 3); mem_stall = 1'b1;
    step(1, HOLD, 1, 0, 0);
    step(1, HOLD, 1, 0, 0);
    step(1, HOLD, 1, 0, 0);
    mem_stall = 1'b0;    step(1, BUB, 2, 0, 0);
                         step(0, CAP, 2, 32'h10A, 32'h203);
    // WB bypass into captured operands
    wb_regwen = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    put(0, 0, 4, 3, 3); id_rs1_data = 32'h1; id_rs2_data = 32'h1;
    step(0, CAP, 2, 32'hDEADBEEF, 32'hDEADBEEF);
    wb_addr = 5'd0;
    put(0, 0, 4, 3, 3); id_rs1_data = 32'h1; id_rs2_data = 32'h1;
    step(0, CAP, 2, 32'h1, 32'h1);
    wb_addr = 5'd3; wb_regwen = 1'b0;
    put(0, 0, 4, 3, 3); id_rs1_data = 32'h1; id_rs2_data = 32'h1;
    step(0, CAP, 2, 32'h1, 32'h1);
    wb_regwen = 1'b1;
    put(0, 0, 4, 3, 5); step(0, CAP, 2, 32'hDEADBEEF, 32'h205);
    wb_regwen = 1'b0;
    // invalid ID instruction captures zeroed control
    put(1, 0, 7, 1, 2); id_valid = 1'b0; step(0, CAP, 2, 32'h101, 32'h202);
    // valid load in EX, then asynchronous reset between edges
    put(1, 0, 12, 1, 2); step(0, CAP, 2, 32'h101, 32'h202);
    drain();
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_ex_valid",   {31'd0, ex_valid},   32'd0);
    chk("arst_ex_rd",      {27'd0, ex_rd},      32'd0);
    chk("arst_ex_memread", {31'd0, ex_memread}, 32'd0);
    chk("arst_ex_ctrl",    {16'd0, ex_ctrl},    32'd0);
    chk("arst_ex_pc",      ex_pc,               32'd0);
    chk("arst_rs1_data",   ex_rs1_data,         32'd0);
    chk("arst_bubble_cnt", bubble_cnt,          32'd0);
    chk("arst_hazard",     {31'd0, hazard_stall}, 32'd0);
    last = '{default: '0};
    @(negedge clk);
    #1;
    rstn = 1'b1;
    // first post-reset edge captures ID (would have been load-use before reset)
    put(0, 0, 6, 12, 2); step(0, CAP, 0, 32'h10C, 32'h202);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
